// File: rtl/vga_card_grid_renderer_if.sv
// Pixel bus between the timing generator, the slot RAM / image ROM and the card renderer.
// master = surrounding system (timing, memories, pins); slave = renderer.
interface vga_card_grid_renderer_if #(
    parameter int PIX_AW = 18
);
    logic [9:0]        x;
    logic [8:0]        y;
    logic              active;
    logic              hSync;
    logic              vSync;
    logic              screenEnd;
    logic [1:0]        winLoss;
    logic [31:0]       slotAddr;
    logic [31:0]       cardIndex;
    logic [PIX_AW-1:0] imgAddr;
    logic [11:0]       pixColor;
    logic              hSyncOut;
    logic              vSyncOut;
    logic [3:0]        VGA_R;
    logic [3:0]        VGA_G;
    logic [3:0]        VGA_B;

    modport master (
        output x, y, active, hSync, vSync, screenEnd, winLoss, cardIndex, pixColor,
        input  slotAddr, imgAddr, hSyncOut, vSyncOut, VGA_R, VGA_G, VGA_B
    );

    modport slave (
        input  x, y, active, hSync, vSync, screenEnd, winLoss, cardIndex, pixColor,
        output slotAddr, imgAddr, hSyncOut, vSyncOut, VGA_R, VGA_G, VGA_B
    );
endinterface

// File: rtl/vga_card_grid_renderer.sv
// Card-grid pixel renderer: slot RAM -> image ROM -> palette -> RGB; optional CARD_BORDER_EN draws black card edges.
// Latency 6 cycles with syncs/active matched; no backpressure, one pixel accepted every cycle.
module vga_card_grid_renderer #(
    parameter int          COLS       = 5,
    parameter int          ROWS       = 2,
    parameter int          CARD_W     = 75,
    parameter int          CARD_H     = 105,
    parameter int          PITCH_X    = 128,
    parameter int          PITCH_Y    = 128,
    parameter int          ORIGIN_X   = 20,
    parameter int          ORIGIN_Y   = 20,
    parameter int          SLOT_BASE  = 16,
    parameter int          CARD_COUNT = 14,
    parameter int          PIX_AW     = 18,
    parameter logic [11:0] BG_COLOR   = 12'hfff
) (
    input logic clk,
    input logic reset,
    vga_card_grid_renderer_if.slave bus
);

    localparam int          CW       = $clog2(COLS + 1);
    localparam int          RW       = $clog2(ROWS + 1);
    localparam int          LXW      = (PITCH_X > 1) ? $clog2(PITCH_X) : 1;
    localparam int          LYW      = (PITCH_Y > 1) ? $clog2(PITCH_Y) : 1;
    localparam int          DEPTH    = 5;
    localparam logic [9:0]  OX       = 10'(ORIGIN_X);
    localparam logic [8:0]  OY       = 9'(ORIGIN_Y);
    localparam logic [31:0] CARD_PIX = 32'(CARD_W * CARD_H);

    logic [CW-1:0]     colR, colCur, colNext;
    logic [LXW-1:0]    lxR, lxCur, lxNext;
    logic [RW-1:0]     rowR, rowLine, rowCur;
    logic [LYW-1:0]    lyR, lyLine, lyCur;
    logic              inGrid, inCard, cardEmpty;
    logic [31:0]       slotNext;
    logic [PIX_AW-1:0] pixAddr;
    logic [LXW-1:0]    lxQ1, lxQ2;
    logic [LYW-1:0]    lyQ1, lyQ2;
    logic [DEPTH-1:0]  actPipe, hsPipe, vsPipe, cardPipe;
    logic [2:0]        emptyPipe;
    logic [1:0]        shadow;
    logic [11:0]       cardPix, rgbNext;

    // Column tracking: x==0 forces the current tile to the origin, so registers only carry state within a line.
    always_comb begin
        colCur  = (bus.x == '0) ? '0 : colR;
        lxCur   = (bus.x == '0) ? '0 : lxR;
        colNext = colCur;
        lxNext  = lxCur;
        if (bus.x >= OX && colCur != CW'(COLS)) begin
            if (lxCur == LXW'(PITCH_X - 1)) begin
                lxNext  = '0;
                colNext = colCur + 1'b1;
            end else begin
                lxNext = lxCur + 1'b1;
            end
        end
    end

    // Row tracking steps once per line, on its x==0 cycle.
    always_comb begin
        rowLine = rowR;
        lyLine  = lyR;
        if (bus.y == '0) begin
            rowLine = '0;
            lyLine  = '0;
        end else if (bus.y > OY && rowR != RW'(ROWS)) begin
            if (lyR == LYW'(PITCH_Y - 1)) begin
                lyLine  = '0;
                rowLine = rowR + 1'b1;
            end else begin
                lyLine = lyR + 1'b1;
            end
        end
        rowCur = (bus.x == '0) ? rowLine : rowR;
        lyCur  = (bus.x == '0) ? lyLine  : lyR;
    end

    always_comb begin
        inGrid   = (bus.x >= OX) && (bus.y >= OY) &&
                   (colCur < CW'(COLS)) && (rowCur < RW'(ROWS));
        inCard   = inGrid && (32'(lxCur) < 32'(CARD_W)) && (32'(lyCur) < 32'(CARD_H));
        slotNext = 32'(SLOT_BASE) + 32'(rowCur) * 32'(COLS) + 32'(colCur);
    end

    always_comb begin
        cardEmpty = (bus.cardIndex >= 32'(CARD_COUNT));
        pixAddr   = PIX_AW'(bus.cardIndex * CARD_PIX + 32'(lyQ2) * 32'(CARD_W) + 32'(lxQ2));
    end

`ifdef CARD_BORDER_EN
    logic [DEPTH-1:0] borderPipe;
    logic             onBorder;

    always_comb begin
        onBorder = (lxCur == '0) || (32'(lxCur) == 32'(CARD_W - 1)) ||
                   (lyCur == '0) || (32'(lyCur) == 32'(CARD_H - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) borderPipe <= '0;
        else       borderPipe <= {borderPipe[DEPTH-2:0], onBorder};
    end

    always_comb cardPix = borderPipe[DEPTH-1] ? 12'h000 : bus.pixColor;
`else
    always_comb cardPix = bus.pixColor;
`endif

    // Overlay wins over card content; inactive area is always black.
    always_comb begin
        rgbNext = 12'h000;
        if (actPipe[DEPTH-1]) begin
            if (shadow == 2'b01)
                rgbNext = 12'h0f0;
            else if (shadow == 2'b10)
                rgbNext = 12'hf00;
            else if (cardPipe[DEPTH-1] && !emptyPipe[2])
                rgbNext = cardPix;
            else
                rgbNext = BG_COLOR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            colR         <= '0;
            lxR          <= '0;
            rowR         <= '0;
            lyR          <= '0;
            bus.slotAddr <= 32'(SLOT_BASE);
            lxQ1         <= '0;
            lxQ2         <= '0;
            lyQ1         <= '0;
            lyQ2         <= '0;
            actPipe      <= '0;
            // Sync stages idle high so the pins never glitch low coming out of reset.
            hsPipe       <= '1;
            vsPipe       <= '1;
            cardPipe     <= '0;
            emptyPipe    <= '0;
            bus.imgAddr  <= '0;
            shadow       <= 2'b00;
            bus.VGA_R    <= '0;
            bus.VGA_G    <= '0;
            bus.VGA_B    <= '0;
            bus.hSyncOut <= 1'b1;
            bus.vSyncOut <= 1'b1;
        end else begin
            colR <= colNext;
            lxR  <= lxNext;
            if (bus.x == '0) begin
                rowR <= rowLine;
                lyR  <= lyLine;
            end
            if (inGrid)
                bus.slotAddr <= slotNext;
            lxQ1      <= lxCur;
            lyQ1      <= lyCur;
            lxQ2      <= lxQ1;
            lyQ2      <= lyQ1;
            actPipe   <= {actPipe[DEPTH-2:0], bus.active};
            hsPipe    <= {hsPipe[DEPTH-2:0], bus.hSync};
            vsPipe    <= {vsPipe[DEPTH-2:0], bus.vSync};
            cardPipe  <= {cardPipe[DEPTH-2:0], inCard};
            emptyPipe <= {emptyPipe[1:0], cardEmpty};
            bus.imgAddr <= cardEmpty ? '0 : pixAddr;
            if (bus.screenEnd)
                shadow <= bus.winLoss;
            {bus.VGA_R, bus.VGA_G, bus.VGA_B} <= rgbNext;
            bus.hSyncOut <= hsPipe[DEPTH-1];
            bus.vSyncOut <= vsPipe[DEPTH-1];
        end
    end

endmodule

// File: tb/tb_vga_card_grid_renderer.sv
// Randomised frame scans against a tile-arithmetic reference model of the card grid renderer.
module tb_vga_card_grid_renderer;
    localparam int COLS = 5, ROWS = 2, CARD_W = 75, CARD_H = 105;
    localparam int PITCH_X = 128, PITCH_Y = 128, ORIGIN_X = 20, ORIGIN_Y = 20;
    localparam int SLOT_BASE = 16, CARD_COUNT = 14;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_card_grid_renderer_if #(.PIX_AW(18)) bus();

    vga_card_grid_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Slot RAM (1-cycle read) and image ROM + palette (2-cycle read).
    logic [31:0] ram [0:31];
    logic [11:0] romQ;

    function automatic logic [11:0] colorOf(input logic [17:0] a);
        colorOf = a[11:0] ^ {a[17:12], a[17:12]} ^ 12'h123;
    endfunction

    always @(posedge clk) begin
        bus.cardIndex <= ram[bus.slotAddr[4:0]];
        romQ          <= colorOf(bus.imgAddr);
        bus.pixColor  <= romQ;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expectations indexed by the cycle at which the output is sampled (mod 8).
    logic [31:0] slotExp [0:7];
    bit          slotChk [0:7];
    logic [17:0] imgExp  [0:7];
    bit          imgChk  [0:7];
    logic [11:0] rgbExp  [0:7];
    logic        hsExp   [0:7];
    logic        vsExp   [0:7];
    bit          outChk  [0:7];

    logic [31:0] lastSlot;
    logic [1:0]  shadow;
    logic [1:0]  wlNow;
    bit          fullLine [0:299];

    task automatic flush();
        for (int k = 0; k < 8; k++) begin
            slotChk[k] = 1'b1;
            slotExp[k] = 32'(SLOT_BASE);
            imgChk[k]  = 1'b0;
            outChk[k]  = 1'b1;
            rgbExp[k]  = 12'h000;
            hsExp[k]   = 1'b1;
            vsExp[k]   = 1'b1;
        end
        lastSlot = 32'(SLOT_BASE);
        shadow   = 2'b00;
    endtask

    task automatic idle();
        bus.x         = '0;
        bus.y         = '0;
        bus.active    = 1'b0;
        bus.hSync     = 1'b1;
        bus.vSync     = 1'b1;
        bus.screenEnd = 1'b0;
        bus.winLoss   = wlNow;
    endtask

    // One pixel clock: check what is due now, then present the next pixel and predict its effects.
    task automatic drivePix(input int px, input int py, input bit act, input bit hs, input bit vs, input bit se);
        int k, col, row, lx, ly, slot;
        bit grid, card, empty, border;
        logic [31:0] idx, full;
        logic [17:0] addr;
        logic [11:0] rgb;
        @(posedge clk);
        #1;
        cyc++;
        k = cyc % 8;
        if (slotChk[k]) checkVal("slotAddr", bus.slotAddr, slotExp[k]);
        if (imgChk[k])  checkVal("imgAddr", 32'(bus.imgAddr), 32'(imgExp[k]));
        if (outChk[k]) begin
            checkVal("rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'(rgbExp[k]));
            checkVal("hSyncOut", 32'(bus.hSyncOut), 32'(hsExp[k]));
            checkVal("vSyncOut", 32'(bus.vSyncOut), 32'(vsExp[k]));
        end

        bus.x         = 10'(px);
        bus.y         = 9'(py);
        bus.active    = act;
        bus.hSync     = hs;
        bus.vSync     = vs;
        bus.screenEnd = se;
        bus.winLoss   = wlNow;

        col = 0; row = 0; lx = 0; ly = 0; grid = 0;
        if (px >= ORIGIN_X && py >= ORIGIN_Y) begin
            col  = (px - ORIGIN_X) / PITCH_X;
            lx   = (px - ORIGIN_X) % PITCH_X;
            row  = (py - ORIGIN_Y) / PITCH_Y;
            ly   = (py - ORIGIN_Y) % PITCH_Y;
            grid = (col < COLS) && (row < ROWS);
        end
        card = grid && (lx < CARD_W) && (ly < CARD_H);
        slot = SLOT_BASE + row * COLS + col;
        if (grid) lastSlot = 32'(slot);
        slotChk[(cyc + 1) % 8] = 1'b1;
        slotExp[(cyc + 1) % 8] = lastSlot;

        idx   = grid ? ram[slot % 32] : 32'd0;
        empty = (idx >= 32'(CARD_COUNT));
        full  = idx * 32'(CARD_W * CARD_H) + 32'(ly * CARD_W + lx);
        addr  = empty ? 18'd0 : full[17:0];
        imgChk[(cyc + 3) % 8] = card;
        imgExp[(cyc + 3) % 8] = addr;

        border = 1'b0;
`ifdef CARD_BORDER_EN
        border = (lx == 0) || (lx == CARD_W - 1) || (ly == 0) || (ly == CARD_H - 1);
`endif
        if (!act)                 rgb = 12'h000;
        else if (shadow == 2'b01) rgb = 12'h0f0;
        else if (shadow == 2'b10) rgb = 12'hf00;
        else if (card && !empty)  rgb = border ? 12'h000 : colorOf(addr);
        else                      rgb = 12'hfff;
        outChk[(cyc + 6) % 8] = 1'b1;
        rgbExp[(cyc + 6) % 8] = rgb;
        hsExp[(cyc + 6) % 8]  = hs;
        vsExp[(cyc + 6) % 8]  = vs;

        if (se) shadow = wlNow;
    endtask

    task automatic midReset();
        #2;
        reset = 1'b1;
        #1;
        checkVal("rstAsync_slotAddr", bus.slotAddr, 32'(SLOT_BASE));
        checkVal("rstAsync_imgAddr", 32'(bus.imgAddr), 32'd0);
        checkVal("rstAsync_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'd0);
        checkVal("rstAsync_hSyncOut", 32'(bus.hSyncOut), 32'd1);
        checkVal("rstAsync_vSyncOut", 32'(bus.vSyncOut), 32'd1);
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        flush();
    endtask

    task automatic pickLines(input int n);
        for (int i = 0; i < 300; i++) fullLine[i] = 1'b0;
        for (int i = 0; i < n; i++) fullLine[$urandom_range(0, 299)] = 1'b1;
    endtask

    task automatic frame(input int wlLine, input logic [1:0] wlMid, input logic [1:0] wlEnd, input int rstLine);
        for (int y = 0; y < 300; y++) begin
            if (y == wlLine) wlNow = wlMid;
            if (fullLine[y]) begin
                for (int x = 0; x < 720; x++) begin
                    drivePix(x, y, (x < 680) && ($urandom_range(0, 15) != 0),
                             $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0, 1'b0);
                    if (y == rstLine && x == 300) begin
                        midReset();
                        return;
                    end
                end
            end else begin
                drivePix(0, y, 1'b0, $urandom_range(0, 3) != 0, 1'b1, 1'b0);
            end
        end
        repeat (6) drivePix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        wlNow = wlEnd;
        drivePix(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (6) drivePix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        wlNow = 2'b00;
        reset = 1'b1;
        idle();
        for (int i = 0; i < 32; i++) ram[i] = 32'($urandom_range(0, CARD_COUNT - 1));
        ram[16] = 32'd3;
        ram[17] = 32'd14;
        ram[20] = 32'h8000_0001;
        repeat (3) @(posedge clk);
        #1;
        checkVal("rst_slotAddr", bus.slotAddr, 32'(SLOT_BASE));
        checkVal("rst_imgAddr", 32'(bus.imgAddr), 32'd0);
        checkVal("rst_rgb", 32'({bus.VGA_R, bus.VGA_G, bus.VGA_B}), 32'd0);
        checkVal("rst_hSyncOut", 32'(bus.hSyncOut), 32'd1);
        checkVal("rst_vSyncOut", 32'(bus.vSyncOut), 32'd1);
        reset = 1'b0;
        flush();

        // Directed lines: slot 0 origin, empty slot 1, slot 6, plus random lines.
        pickLines(4);
        fullLine[20] = 1'b1; fullLine[50] = 1'b1; fullLine[148] = 1'b1;
        frame(-1, 2'b00, 2'b00, -1);

        // Win requested mid-frame: takes effect only from the next frame.
        pickLines(5);
        fullLine[20] = 1'b1;
        frame(100, 2'b01, 2'b01, -1);

        // Green frame; 11 requested mid-frame renders normally afterwards.
        pickLines(5);
        frame(100, 2'b11, 2'b11, -1);

        pickLines(5);
        fullLine[148] = 1'b1;
        frame(150, 2'b10, 2'b10, -1);

        // Red frame interrupted by a reset mid-line.
        pickLines(3);
        fullLine[148] = 1'b1;
        frame(-1, 2'b10, 2'b10, 148);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 32; i++)
                ram[i] = ($urandom_range(0, 5) == 0) ? $urandom : 32'($urandom_range(0, 15));
            pickLines(5);
            frame(-1, wlNow, 2'($urandom_range(0, 3)), -1);
        end
        pickLines(5);
        frame(-1, wlNow, 2'b00, -1);
        pickLines(5);
        frame(-1, wlNow, 2'b00, -1);
        repeat (8) drivePix(0, 0, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_card_grid_renderer.md
# vga_card_grid_renderer

Parametrised pixel pipeline that turns timing-generator coordinates into a grid of card sprites, fetching each slot's card index from data RAM and the sprite's pixel through external image ROM/palette memories. Sits between the VGA timing generator and the VGA pins. Generalises the fixed 5×2 card layout to any grid geometry. Adds latency-matched syncs, line-tracked tile counters (no dividers), empty-slot handling and frame-synchronous win/loss overlays.

## Interface
- COLS, 5, card columns
- ROWS, 2, card rows
- CARD_W, 75, sprite width in pixels
- CARD_H, 105, sprite height in pixels
- PITCH_X, 128, horizontal slot pitch; must be ≥ CARD_W
- PITCH_Y, 128, vertical slot pitch; must be ≥ CARD_H
- ORIGIN_X, 20, left edge of slot 0
- ORIGIN_Y, 20, top edge of slot 0
- SLOT_BASE, 16, RAM word address of slot 0 (row-major)
- CARD_COUNT, 14, valid sprite count; index ≥ CARD_COUNT means empty
- PIX_AW, 18, image ROM address width
- BG_COLOR, 12'hfff, background colour

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
- x  in  10  pixel column from timing generator
- y  in  9  pixel row
- active  in  1  visible-area flag
- hSync, vSync  in  1 each  raw syncs
- screenEnd  in  1  one-cycle end-of-frame pulse
- winLoss  in  2  00 none, 01 win, 10 loss, 11 treated as none
- slotAddr  out  32  data-RAM address of current slot
- cardIndex  in  32  RAM data, valid 1 cycle after slotAddr
- imgAddr  out  PIX_AW  image ROM address
- pixColor  in  12  palette output, valid 2 cycles after imgAddr
- hSyncOut, vSyncOut  out  1 each  syncs delayed to match colour
- VGA_R, VGA_G, VGA_B  out  4 each  colour

## Operation
- Tile tracking: on x==0 the column counter clears and the offset counter loads 0. The counters advance only when x ≥ ORIGIN_X. The offset wraps at PITCH_X-1 and increments col. Col saturates at COLS, meaning outside the grid.
- Row counters follow the same scheme: they update on the first cycle of each line (x==0) using y and ORIGIN_Y/PITCH_Y, and saturate at ROWS. On y==0 they clear.
- inCard is true when col<COLS, row<ROWS, lx<CARD_W and ly<CARD_H, where lx and ly are the in-tile offsets.
- slotAddr = SLOT_BASE + row·COLS + col. Outside the grid it holds its last value.
- imgAddr = cardIndex·CARD_W·CARD_H + ly·CARD_W + lx, computed in 32 bits and truncated to PIX_AW. If the card is empty (cardIndex ≥ CARD_COUNT), imgAddr = 0 and the pixel renders as BG_COLOR.
- Overlay: winLoss is sampled only on screenEnd into a shadow register. Shadow 01 gives a full-frame 12'h0f0; shadow 10 gives 12'hf00. Otherwise the output is pixColor inside a non-empty card and BG_COLOR elsewhere.
- When the delayed active flag is low, the output colour is 0.

## Timing
- Pipeline for an input pixel at cycle N:
  - slotAddr registered at N+1
  - cardIndex sampled at N+2
  - imgAddr registered at N+3
  - pixColor sampled at N+5
  - RGB registered at N+6
- Total latency is 6 cycles. hSync, vSync, active and the inCard/empty flags are delayed by 6 stages to match.
- Reset values:
  - slotAddr = SLOT_BASE
  - imgAddr = 0
  - VGA_R/G/B = 0
  - hSyncOut = vSyncOut = 1
  - shadow winLoss = 00
  - all counters and pipeline flags = 0
- Reset asserted mid-frame clears everything immediately. Output stays black until 6 cycles after the first pixel following release.
- If winLoss changes mid-frame, the output is unaffected until the next screenEnd. If screenEnd and a winLoss change arrive in the same cycle, the new value is captured.

## Configuration
- CARD_BORDER_EN defined: pixels with lx ∈ {0, CARD_W-1} or ly ∈ {0, CARD_H-1} inside a non-empty card render 12'h000 instead of pixColor. The border is suppressed by an active overlay.
- Not defined: no border logic; card pixels are always pixColor.

## Test plan
- Defaults; slot RAM[16]=3. Drive x=20, y=20, active=1 → slotAddr=16 at N+1, imgAddr=23625 at N+3. With pixColor=12'h123 at N+5, RGB=12'h123 at N+6.
- x=95 (lx=75), y=20 → BG_COLOR 12'hfff at N+6. x=148, y=148 → slotAddr=22 (slot 6).
- RAM[17]=14 (empty), x=150, y=50 → imgAddr=0, RGB=12'hfff.
- winLoss=01 mid-frame → no change until screenEnd, then every visible pixel is 12'h0f0. winLoss=11 → normal render.
- Toggle hSync and active at cycle N → hSyncOut follows at N+6, and RGB=0 while delayed active is low.
- Reset pulse mid-line → outputs return to reset values within the same cycle. With CARD_BORDER_EN, x=20, y=20 → RGB=12'h000.
